button_conditioner: RTL and testbench
=====================================

# button_conditioner

Conditions the raw push-button inputs of the board into clean, single-cycle load strobes for the operand/opcode load stage that feeds the ALU. Each button is optionally synchronised, then debounced by a per-button state machine and counter. A press produces exactly one `o_pulses` bit for one clock. This block drives the 3-bit button input of the load stage directly.

## Interface
- `NB_BUTTONS`, 3: number of independent button channels.
- `DEBOUNCE_CYCLES`, 1000000: consecutive samples of a new level required before it is accepted (10 ms at 100 MHz). Must be ≥ 2.
- `i_clock`, in, 1: clock; all logic on the rising edge.
- `i_reset`, in, 1: reset, synchronous, active-high.
- `i_buttons`, in, `NB_BUTTONS`: raw, bouncing, asynchronous button levels, active-high.
- `o_pulses`, out, `NB_BUTTONS`: one-cycle strobe per accepted press (debounced 0→1). Feeds the load stage.
- `o_levels`, out, `NB_BUTTONS`: debounced level of each button.

## Operation
- Channels are fully independent. Multiple buttons may pulse in the same cycle; the downstream stage accepts all of them.
- Per-channel state machine, with sampled input `s` and counter `cnt`:
  - IDLE_LOW: `s`=1 → WAIT_HIGH, `cnt`←1. Otherwise stay, `cnt`←0.
  - WAIT_HIGH: `s`=0 → IDLE_LOW, `cnt`←0. `s`=1 and `cnt`=`DEBOUNCE_CYCLES`−1 → IDLE_HIGH, `cnt`←0, pulse←1. Otherwise `cnt`←`cnt`+1.
  - IDLE_HIGH: `s`=0 → WAIT_LOW, `cnt`←1. Otherwise stay.
  - WAIT_LOW: `s`=1 → IDLE_HIGH, `cnt`←0. `s`=0 and `cnt`=`DEBOUNCE_CYCLES`−1 → IDLE_LOW, `cnt`←0, with no pulse. Otherwise `cnt`←`cnt`+1.
- `o_levels` is 1 in IDLE_HIGH and WAIT_LOW, and 0 otherwise. It is registered, i.e. derived from the state register.
- `o_pulses` is registered. It is high only in the cycle after the WAIT_HIGH→IDLE_HIGH transition. Releases never pulse.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter never exceeds `DEBOUNCE_CYCLES`−1, so it has no wrap-around.
- Any bounce during a WAIT state returns the channel to its IDLE state and restarts the count from zero.
- A button held forever produces one pulse only.

## Timing
- Reset values: every state is IDLE_LOW, `cnt`=0, `o_pulses`=0, `o_levels`=0, synchroniser flops=0.
- Reset mid-count abandons the count, and no pulse is emitted.
- A button held through reset is treated as a new press. Its pulse arrives `DEBOUNCE_CYCLES` (+2 with sync) edges after the first non-reset edge.
- Latency without sync: when the input is high at `DEBOUNCE_CYCLES` consecutive edges, `o_pulses` is high for the cycle following the last of those edges.
- With sync: add 2 cycles.
- Pulse width is exactly 1 cycle.
- Minimum spacing between two pulses on one channel is 2·`DEBOUNCE_CYCLES` edges.

## Configuration
- `BTN_SYNC_EN` defined: each `i_buttons` bit passes through a 2-flop synchroniser before the state machine, adding 2 cycles of latency.
- `BTN_SYNC_EN` not defined: the state machine samples `i_buttons` directly. This mode is for simulation and for inputs that are already synchronous.

## Structure
- Shared package/header `btn_pkg`: state encodings (IDLE_LOW=2'b00, WAIT_HIGH=2'b01, IDLE_HIGH=2'b10, WAIT_LOW=2'b11) and the default `DEBOUNCE_CYCLES` constant.
- Sub-module `btn_debounce_cell`: one channel, comprising the optional synchroniser, the state machine and the counter. The top level instantiates `NB_BUTTONS` cells in a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 with `BTN_SYNC_EN` off unless stated.
- Clean press: hold `i_buttons`=3'b001 from edge 0 → `o_pulses`=3'b001 for exactly the cycle after edge 3, then 0; `o_levels[0]`=1 from that cycle onward.
- Bounce: pattern 1,1,0,1,1,1,1 on bit 1 → exactly one pulse, after the 4th consecutive 1 (edge 6); no earlier pulse.
- Release: after a press, drop bit 0 for 4 edges → `o_levels[0]`=0, no pulse. A 3-edge drop followed by high → `o_levels[0]` stays 1.
- Simultaneous: bits 0 and 2 rise on the same edge → `o_pulses`=3'b101 in one cycle.
- Reset mid-operation: assert `i_reset` at `cnt`=2 while the button stays high → no pulse during reset. All outputs are 0, and a pulse follows 4 edges after reset release.
- `BTN_SYNC_EN` defined: the clean press scenario yields the pulse 2 cycles later (after edge 5).

Source files
------------

// File: rtl/btn_pkg.sv
// ============================================================================
// Module : btn_pkg
// Shared debounce state encodings and default sizing for button_conditioner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package btn_pkg;

    localparam int NB_BUTTONS_DEFAULT      = 3;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    localparam logic [1:0] IDLE_LOW  = 2'b00;
    localparam logic [1:0] WAIT_HIGH = 2'b01;
    localparam logic [1:0] IDLE_HIGH = 2'b10;
    localparam logic [1:0] WAIT_LOW  = 2'b11;

endpackage : btn_pkg

`default_nettype wire

// File: rtl/button_conditioner_if.sv
// ============================================================================
// Module : button_conditioner_if
// Raw button levels in, conditioned strobes and debounced levels out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface button_conditioner_if
    import btn_pkg::*;
#(
    parameter int NB_BUTTONS = NB_BUTTONS_DEFAULT
);

    logic [NB_BUTTONS-1:0] i_buttons;
    logic [NB_BUTTONS-1:0] o_pulses;
    logic [NB_BUTTONS-1:0] o_levels;

    modport master (
        output i_buttons,
        input  o_pulses,
        input  o_levels
    );

    modport slave (
        input  i_buttons,
        output o_pulses,
        output o_levels
    );

endinterface : button_conditioner_if

`default_nettype wire

// File: rtl/btn_debounce_cell.sv
// ============================================================================
// Module : btn_debounce_cell
// One button channel: optional 2-flop synchroniser (BTN_SYNC_EN), debounce
// state machine and run-length counter. Emits a one-cycle strobe per press.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btn_debounce_cell
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  wire logic i_clock,
    input  wire logic i_reset,
    input  wire logic button_i,
    output logic      pulse_o,
    output logic      level_o
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pulse_q, pulse_d;

`ifdef BTN_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], button_i};
        end
    end

    assign w_s = sync_q[1];
`else
    assign w_s = button_i;
`endif

    // The counter holds how many consecutive samples of the candidate level
    // have been seen; any bounce sends the channel back to its idle state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (w_s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!w_s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!w_s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (w_s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Debounced level is high exactly in IDLE_HIGH and WAIT_LOW.
    assign level_o = state_q[1];
    assign pulse_o = pulse_q;

endmodule : btn_debounce_cell

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module : button_conditioner
// NB_BUTTONS independent debounce channels producing load strobes.
// Optional input synchronisers are enabled with the BTN_SYNC_EN macro.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_conditioner
    import btn_pkg::*;
#(
    parameter int NB_BUTTONS      = NB_BUTTONS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  wire logic            i_clock,
    input  wire logic            i_reset,
    button_conditioner_if.slave  bus
);

    logic [NB_BUTTONS-1:0] w_pulses;
    logic [NB_BUTTONS-1:0] w_levels;

    for (genvar g = 0; g < NB_BUTTONS; g++) begin : g_cell
        btn_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .i_clock  (i_clock),
            .i_reset  (i_reset),
            .button_i (bus.i_buttons[g]),
            .pulse_o  (w_pulses[g]),
            .level_o  (w_levels[g])
        );
    end

    assign bus.o_pulses = w_pulses;
    assign bus.o_levels = w_levels;

endmodule : button_conditioner

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module : tb_button_conditioner
// Directed bench for button_conditioner with a run-length reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_button_conditioner;

    localparam int NB  = 3;
    localparam int DC  = 4;
`ifdef BTN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    bit   check_en;

    button_conditioner_if #(.NB_BUTTONS(NB)) bus ();

    button_conditioner #(
        .NB_BUTTONS      (NB),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Reference model: a level flips once DC consecutive samples disagree
    // with it; a flip to 1 yields a strobe in the following cycle.
    logic [NB-1:0] m_lvl;
    logic [NB-1:0] m_pulse;
    int            m_run [NB];
`ifdef BTN_SYNC_EN
    logic [NB-1:0] m_d1, m_d2;
`endif

    always @(posedge clk) begin
        logic [NB-1:0] s;
        if (rst) begin
            m_lvl   = '0;
            m_pulse = '0;
            for (int c = 0; c < NB; c++) m_run[c] = 0;
`ifdef BTN_SYNC_EN
            m_d1 = '0;
            m_d2 = '0;
`endif
        end else begin
`ifdef BTN_SYNC_EN
            s    = m_d2;
            m_d2 = m_d1;
            m_d1 = bus.i_buttons;
`else
            s    = bus.i_buttons;
`endif
            m_pulse = '0;
            for (int c = 0; c < NB; c++) begin
                if (s[c] != m_lvl[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == DC) begin
                        m_lvl[c]   = s[c];
                        m_run[c]   = 0;
                        m_pulse[c] = s[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_pulses", bus.o_pulses, m_pulse);
            chk("model_levels", bus.o_levels, m_lvl);
        end
    end

    // One clock edge consumes the applied vector; returns at the next negedge.
    task automatic cyc(input logic [NB-1:0] b);
        bus.i_buttons = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        check_en = 1'b0;
        rst      = 1'b1;
        bus.i_buttons = '0;
        cyc(3'b000);
        check_en = 1'b1;
        cyc(3'b000);
        chk("reset_pulses", bus.o_pulses, 3'b000);
        chk("reset_levels", bus.o_levels, 3'b000);
        rst = 1'b0;

        // Clean press on bit 0
        for (int i = 0; i < DC + LAT; i++) begin
            cyc(3'b001);
            if (i == DC - 1 + LAT) chk("press_pulse", bus.o_pulses, 3'b001);
            else                   chk("press_nopulse", bus.o_pulses, 3'b000);
        end
        cyc(3'b001);
        chk("press_width", bus.o_pulses, 3'b000);
        chk("press_level", bus.o_levels, 3'b001);

        // Short 3-edge release is rejected
        repeat (3) cyc(3'b000);
        repeat (3 + LAT) cyc(3'b001);
        chk("short_drop_level", bus.o_levels, 3'b001);

        // Full release: level drops, no strobe
        for (int i = 0; i < DC + LAT; i++) begin
            cyc(3'b000);
            chk("release_nopulse", bus.o_pulses, 3'b000);
        end
        chk("release_level", bus.o_levels, 3'b000);

        // Bounce on bit 1: 1,1,0,1,1,1,1
        begin
            logic [6:0] pat;
            pat = 7'b1111011;
            for (int i = 0; i < 7; i++) begin
                cyc({1'b0, pat[i], 1'b0});
                if (i == 6 && LAT == 0) chk("bounce_pulse", bus.o_pulses, 3'b010);
                else                    chk("bounce_nopulse", bus.o_pulses, 3'b000);
            end
            for (int i = 0; i < LAT; i++) begin
                cyc(3'b010);
                if (i == LAT - 1) chk("bounce_pulse", bus.o_pulses, 3'b010);
            end
        end
        repeat (DC + LAT + 1) cyc(3'b000);
        chk("bounce_released", bus.o_levels, 3'b000);

        // Simultaneous press on bits 0 and 2, then held
        repeat (DC + LAT) cyc(3'b101);
        chk("simul_pulse", bus.o_pulses, 3'b101);
        repeat (12) begin
            cyc(3'b101);
            chk("held_nopulse", bus.o_pulses, 3'b000);
        end
        chk("held_level", bus.o_levels, 3'b101);
        repeat (DC + LAT + 1) cyc(3'b000);

        // Reset in the middle of a count with the button held
        repeat (2 + LAT) cyc(3'b001);
        rst = 1'b1;
        repeat (3) begin
            cyc(3'b001);
            chk("rst_pulses", bus.o_pulses, 3'b000);
            chk("rst_levels", bus.o_levels, 3'b000);
        end
        rst = 1'b0;
        for (int i = 0; i < DC + LAT; i++) begin
            cyc(3'b001);
            if (i == DC - 1 + LAT) chk("post_rst_pulse", bus.o_pulses, 3'b001);
            else                   chk("post_rst_nopulse", bus.o_pulses, 3'b000);
        end
        cyc(3'b001);
        chk("post_rst_level", bus.o_levels, 3'b001);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_button_conditioner

`default_nettype wire
